// File: rtl/igr_ppe_pkg.sv
// Shared types and defaults for the ingress-to-PPE header transmitter.
package igr_ppe_pkg;

    localparam int SEG_DATA_W   = 512;
    localparam int SEG_MD_W     = 32;
    localparam int HDR_SEGS_DEF = 4;
    localparam int CREDITS_DEF  = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FWD  = 2'd1,
        DROP = 2'd2
    } state_e;

    // Holds one forwarded segment; DATA_W/MD_W of the top must not exceed these widths.
    typedef struct packed {
        logic [SEG_DATA_W-1:0] data;
        logic                  sop;
        logic                  eop;
        logic [SEG_MD_W-1:0]   md;
        logic                  trunc;
    } seg_t;

endpackage

// File: rtl/igr_ppe_credit_ctr.sv
// Saturating credit counter toward the parser; flags a return that would overflow.
module igr_ppe_credit_ctr
    import igr_ppe_pkg::*;
#(
    parameter int CREDITS = CREDITS_DEF
) (
    input  logic                         cclk,
    input  logic                         reset_n,
    input  logic                         take_i,
    input  logic                         ret_i,
    output logic [$clog2(CREDITS+1)-1:0] cnt_o,
    output logic                         ovf_o
);

    localparam int CW = $clog2(CREDITS+1);
    localparam logic [CW-1:0] FULL = CW'(CREDITS);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        ovf_o = 1'b0;
        case ({take_i, ret_i})
            2'b10: cnt_d = cnt_q - CW'(1);
            2'b01: begin
                if (cnt_q == FULL) begin
                    ovf_o = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge cclk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= FULL;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/igr_ppe_hdr_tx.sv
// Forwards the first HDR_SEGS segments of each ingress packet to the parser under
// credit flow control, marking truncated headers and keeping saturating statistics.
module igr_ppe_hdr_tx
    import igr_ppe_pkg::*;
#(
    parameter int DATA_W   = SEG_DATA_W,
    parameter int MD_W     = SEG_MD_W,
    parameter int HDR_SEGS = HDR_SEGS_DEF,
    parameter int CREDITS  = CREDITS_DEF
) (
    input  logic              cclk,
    input  logic              reset_n,
    input  logic              cfg_enable,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_sop,
    input  logic              in_eop,
    input  logic [MD_W-1:0]   in_md,
    output logic              ppe_valid,
    output logic [DATA_W-1:0] ppe_data,
    output logic              ppe_sop,
    output logic              ppe_eop,
    output logic [MD_W-1:0]   ppe_md,
    output logic              ppe_trunc,
    input  logic              ppe_credit,
    output logic [31:0]       pkt_cnt,
    output logic [15:0]       trunc_cnt,
    output logic [15:0]       err_cnt
);

    localparam int CW = $clog2(CREDITS+1);
    localparam int SW = $clog2(HDR_SEGS+1);
    localparam logic [SW-1:0] SEG_LAST = SW'(HDR_SEGS);

    state_e        state_q, state_d;
    logic [SW-1:0] seg_cnt_q, seg_cnt_d;
    logic          run_q;
    logic          ppe_valid_q;
    seg_t          seg_q, seg_d;
    logic [31:0]   pkt_cnt_q, pkt_cnt_d;
    logic [15:0]   trunc_cnt_q, trunc_cnt_d;
    logic [15:0]   err_cnt_q, err_cnt_d;

    logic [CW-1:0] credit_cnt;
    logic          credit_ok;
    logic          credit_ovf;
    logic          accept;
    logic          fwd;
    logic          out_sop;
    logic          out_eop;
    logic          out_trunc;
    logic          proto_err;
    logic [SW-1:0] seg_inc;
    logic [1:0]    err_inc;
    logic [16:0]   err_sum;

    igr_ppe_credit_ctr #(
        .CREDITS (CREDITS)
    ) u_credit (
        .cclk    (cclk),
        .reset_n (reset_n),
        .take_i  (fwd),
        .ret_i   (ppe_credit),
        .cnt_o   (credit_cnt),
        .ovf_o   (credit_ovf)
    );

    assign credit_ok = (credit_cnt != '0);
    assign accept    = in_valid && in_ready;
    assign seg_inc   = seg_cnt_q + SW'(1);

    // run_q keeps in_ready low while reset is asserted and for the first cycle after.
    always_comb begin
        in_ready = 1'b0;
        case (state_q)
            IDLE:    in_ready = run_q && cfg_enable && credit_ok;
            FWD:     in_ready = credit_ok;
            DROP:    in_ready = 1'b1;
            default: in_ready = 1'b0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        seg_cnt_d = seg_cnt_q;
        fwd       = 1'b0;
        out_sop   = 1'b0;
        out_eop   = 1'b0;
        out_trunc = 1'b0;
        proto_err = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (in_sop) begin
                        fwd     = 1'b1;
                        out_sop = 1'b1;
                        if (in_eop) begin
                            out_eop   = 1'b1;
                            seg_cnt_d = '0;
                        end else begin
                            seg_cnt_d = SW'(1);
                            state_d   = FWD;
                        end
                    end else begin
                        proto_err = 1'b1;
                    end
                end
            end
            FWD: begin
                if (accept) begin
                    fwd = 1'b1;
                    if (in_sop) begin
                        // An unterminated packet is abandoned; this beat restarts the count.
                        proto_err = 1'b1;
                        out_sop   = 1'b1;
                        if (in_eop) begin
                            out_eop   = 1'b1;
                            seg_cnt_d = '0;
                            state_d   = IDLE;
                        end else begin
                            seg_cnt_d = SW'(1);
                        end
                    end else if (in_eop) begin
                        out_eop   = 1'b1;
                        seg_cnt_d = '0;
                        state_d   = IDLE;
                    end else if (seg_inc == SEG_LAST) begin
                        out_eop   = 1'b1;
                        out_trunc = 1'b1;
                        seg_cnt_d = seg_inc;
                        state_d   = DROP;
                    end else begin
                        seg_cnt_d = seg_inc;
                    end
                end
            end
            DROP: begin
                if (accept && in_eop) begin
                    seg_cnt_d = '0;
                    state_d   = IDLE;
                end
            end
            default: begin
                seg_cnt_d = '0;
                state_d   = IDLE;
            end
        endcase
    end

    always_comb begin
        seg_d = seg_q;
        if (fwd) begin
            seg_d.data  = SEG_DATA_W'(in_data);
            seg_d.sop   = out_sop;
            seg_d.eop   = out_eop;
            seg_d.md    = SEG_MD_W'(in_md);
            seg_d.trunc = out_trunc;
        end
    end

    always_comb begin
        pkt_cnt_d   = pkt_cnt_q;
        trunc_cnt_d = trunc_cnt_q;
        if (fwd && out_eop && (pkt_cnt_q != '1)) begin
            pkt_cnt_d = pkt_cnt_q + 32'd1;
        end
        if (out_trunc && (trunc_cnt_q != '1)) begin
            trunc_cnt_d = trunc_cnt_q + 16'd1;
        end
        // A protocol error and a credit overflow may land in the same cycle.
        err_inc   = {1'b0, proto_err} + {1'b0, credit_ovf};
        err_sum   = {1'b0, err_cnt_q} + {15'd0, err_inc};
        err_cnt_d = err_sum[16] ? 16'hFFFF : err_sum[15:0];
    end

    always_ff @(posedge cclk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            seg_cnt_q   <= '0;
            run_q       <= 1'b0;
            ppe_valid_q <= 1'b0;
            seg_q       <= '0;
            pkt_cnt_q   <= '0;
            trunc_cnt_q <= '0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            seg_cnt_q   <= seg_cnt_d;
            run_q       <= 1'b1;
            ppe_valid_q <= fwd;
            seg_q       <= seg_d;
            pkt_cnt_q   <= pkt_cnt_d;
            trunc_cnt_q <= trunc_cnt_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign ppe_valid = ppe_valid_q;
    assign ppe_data  = seg_q.data[DATA_W-1:0];
    assign ppe_md    = seg_q.md[MD_W-1:0];
    assign ppe_sop   = ppe_valid_q && seg_q.sop;
    assign ppe_eop   = ppe_valid_q && seg_q.eop;
    assign ppe_trunc = ppe_valid_q && seg_q.trunc;
    assign pkt_cnt   = pkt_cnt_q;
    assign trunc_cnt = trunc_cnt_q;
    assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_igr_ppe_hdr_tx.sv
// Scoreboard bench for igr_ppe_hdr_tx: stimulus pushes expected parser beats, a monitor checks them.
module tb_igr_ppe_hdr_tx;
    import igr_ppe_pkg::*;

    localparam int DATA_W = 512;
    localparam int MD_W   = 32;

    logic              cclk = 1'b0;
    logic              reset_n = 1'b0;
    logic              cfg_enable = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [DATA_W-1:0] in_data = '0;
    logic              in_sop = 1'b0;
    logic              in_eop = 1'b0;
    logic [MD_W-1:0]   in_md = '0;
    logic              ppe_valid;
    logic [DATA_W-1:0] ppe_data;
    logic              ppe_sop;
    logic              ppe_eop;
    logic [MD_W-1:0]   ppe_md;
    logic              ppe_trunc;
    logic              ppe_credit = 1'b0;
    logic [31:0]       pkt_cnt;
    logic [15:0]       trunc_cnt;
    logic [15:0]       err_cnt;

    typedef struct {
        logic [DATA_W-1:0] data;
        logic              sop;
        logic              eop;
        logic              trunc;
        logic [MD_W-1:0]   md;
        int                cyc;
    } exp_t;

    exp_t sb_q[$];
    int   cyc = 0;
    int   pass_cnt = 0;
    int   total_cnt = 0;

    igr_ppe_hdr_tx u_dut (
        .cclk       (cclk),
        .reset_n    (reset_n),
        .cfg_enable (cfg_enable),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_sop     (in_sop),
        .in_eop     (in_eop),
        .in_md      (in_md),
        .ppe_valid  (ppe_valid),
        .ppe_data   (ppe_data),
        .ppe_sop    (ppe_sop),
        .ppe_eop    (ppe_eop),
        .ppe_md     (ppe_md),
        .ppe_trunc  (ppe_trunc),
        .ppe_credit (ppe_credit),
        .pkt_cnt    (pkt_cnt),
        .trunc_cnt  (trunc_cnt),
        .err_cnt    (err_cnt)
    );

    always #5 cclk = ~cclk;

    always @(posedge cclk) cyc <= cyc + 1;

    always @(negedge cclk) begin
        if (ppe_valid) begin
            total_cnt++;
            if (sb_q.size() == 0) begin
                $display("FAIL unexpected_beat: data=%h sop=%0d eop=%0d at cycle %0d, none expected",
                         ppe_data[31:0], ppe_sop, ppe_eop, cyc);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                if (ppe_data === e.data && ppe_sop === e.sop && ppe_eop === e.eop &&
                    ppe_trunc === e.trunc && (!e.sop || ppe_md === e.md) && cyc == e.cyc) begin
                    pass_cnt++;
                end else begin
                    $display("FAIL beat: got data=%h sop=%0d eop=%0d trunc=%0d md=%h cyc=%0d; expected data=%h sop=%0d eop=%0d trunc=%0d md=%h cyc=%0d",
                             ppe_data[31:0], ppe_sop, ppe_eop, ppe_trunc, ppe_md, cyc,
                             e.data[31:0], e.sop, e.eop, e.trunc, e.md, e.cyc);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic send_beat(input logic [31:0] d, input logic sop, input logic eop,
                             input logic [31:0] md, input logic exp_fwd,
                             input logic exp_eop, input logic exp_trunc);
        int  waited = 0;
        bit  done = 0;
        in_valid = 1'b1;
        in_data  = {16{d}};
        in_sop   = sop;
        in_eop   = eop;
        in_md    = md;
        while (!done) begin
            if (in_ready) begin
                if (exp_fwd) begin
                    exp_t e;
                    e.data  = {16{d}};
                    e.sop   = sop;
                    e.eop   = exp_eop;
                    e.trunc = exp_trunc;
                    e.md    = md;
                    e.cyc   = cyc + 1;
                    sb_q.push_back(e);
                end
                @(posedge cclk);
                #1;
                done = 1;
            end else if (waited >= 50) begin
                total_cnt++;
                $display("FAIL accept_timeout: beat %h not accepted after %0d cycles, expected acceptance", d, waited);
                done = 1;
            end else begin
                waited++;
                @(posedge cclk);
                #1;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (sb_q.size() != 0 && n < 50) begin
            @(posedge cclk);
            #1;
            n++;
        end
        check("drain", sb_q.size(), 0);
        @(posedge cclk);
        #1;
    endtask

    task automatic return_credits(input int n);
        ppe_credit = 1'b1;
        repeat (n) @(posedge cclk);
        #1;
        ppe_credit = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge cclk);
        #1;
        reset_n = 1'b1;
        repeat (2) @(posedge cclk);
        #1;
        check("rst_in_ready", in_ready, 0);
        check("rst_ppe_valid", ppe_valid, 0);
        check("rst_ppe_data", ppe_data[31:0], 0);
        check("rst_pkt_cnt", pkt_cnt, 0);
        check("rst_trunc_cnt", trunc_cnt, 0);
        check("rst_err_cnt", err_cnt, 0);
        check("rst_credit", u_dut.credit_cnt, 8);
        cfg_enable = 1'b1;
        #1;
        check("enable_ready", in_ready, 1);
        @(posedge cclk);
        #1;

        // Two-segment packet
        send_beat(32'hA000_0001, 1, 0, 32'h0000_1111, 1, 0, 0);
        send_beat(32'hA000_0002, 0, 1, 32'h0, 1, 1, 0);
        wait_drain();
        check("t1_pkt_cnt", pkt_cnt, 1);
        check("t1_trunc_cnt", trunc_cnt, 0);
        check("t1_credit", u_dut.credit_cnt, 6);
        return_credits(2);
        check("t1_credit_back", u_dut.credit_cnt, 8);

        // Seven-segment packet truncated after four
        send_beat(32'hB000_0001, 1, 0, 32'h0000_2222, 1, 0, 0);
        send_beat(32'hB000_0002, 0, 0, 32'h0, 1, 0, 0);
        send_beat(32'hB000_0003, 0, 0, 32'h0, 1, 0, 0);
        send_beat(32'hB000_0004, 0, 0, 32'h0, 1, 1, 1);
        send_beat(32'hB000_0005, 0, 0, 32'h0, 0, 0, 0);
        send_beat(32'hB000_0006, 0, 0, 32'h0, 0, 0, 0);
        send_beat(32'hB000_0007, 0, 1, 32'h0, 0, 0, 0);
        wait_drain();
        check("t2_trunc_cnt", trunc_cnt, 1);
        check("t2_pkt_cnt", pkt_cnt, 2);
        check("t2_credit", u_dut.credit_cnt, 4);
        check("t2_err_cnt", err_cnt, 0);
        return_credits(4);

        // Credit exhaustion with back-to-back single-segment packets
        for (int i = 0; i < 8; i++) begin
            send_beat(32'hC000_0000 + 32'(i), 1, 1, 32'h0000_3300 + 32'(i), 1, 1, 0);
        end
        check("t3_ready_empty", in_ready, 0);
        check("t3_credit_empty", u_dut.credit_cnt, 0);
        fork
            send_beat(32'hC000_0008, 1, 1, 32'h0000_3308, 1, 1, 0);
            begin
                repeat (3) @(posedge cclk);
                #1;
                ppe_credit = 1'b1;
                @(posedge cclk);
                #1;
                ppe_credit = 1'b0;
            end
        join
        check("t3_ready_after", in_ready, 0);
        wait_drain();
        check("t3_pkt_cnt", pkt_cnt, 11);
        check("t3_credit_after", u_dut.credit_cnt, 0);
        return_credits(8);

        // Protocol errors: non-sop in IDLE, sop in FWD
        send_beat(32'hD000_0001, 0, 1, 32'h0, 0, 0, 0);
        @(posedge cclk);
        #1;
        check("t4_err_nonsop", err_cnt, 1);
        send_beat(32'hE000_0001, 1, 0, 32'h0000_4401, 1, 0, 0);
        send_beat(32'hE000_0002, 1, 1, 32'h0000_4402, 1, 1, 0);
        wait_drain();
        check("t4_err_sop_fwd", err_cnt, 2);
        check("t4_pkt_cnt", pkt_cnt, 12);
        check("t4_credit", u_dut.credit_cnt, 6);
        return_credits(2);

        // Credit return while full
        return_credits(1);
        @(posedge cclk);
        #1;
        check("t5_credit_sat", u_dut.credit_cnt, 8);
        check("t5_err_ovf", err_cnt, 3);

        // Reset in the middle of a packet
        for (int i = 0; i < 3; i++) begin
            send_beat(32'hF000_0000 + 32'(i), 1, 1, 32'h0000_5500 + 32'(i), 1, 1, 0);
        end
        send_beat(32'h6000_0001, 1, 0, 32'h0000_6601, 1, 0, 0);
        send_beat(32'h6000_0002, 0, 0, 32'h0, 1, 0, 0);
        wait_drain();
        check("t6_credit_pre", u_dut.credit_cnt, 3);
        check("t6_state_pre", 32'(u_dut.state_q), 32'(FWD));
        check("t6_pkt_pre", pkt_cnt, 15);
        #2;
        reset_n = 1'b0;
        #2;
        check("t6_rst_valid", ppe_valid, 0);
        check("t6_rst_data", ppe_data[31:0], 0);
        check("t6_rst_sop_eop", {ppe_sop, ppe_eop, ppe_trunc}, 0);
        check("t6_rst_ready", in_ready, 0);
        check("t6_rst_pkt", pkt_cnt, 0);
        check("t6_rst_err", err_cnt, 0);
        check("t6_rst_credit", u_dut.credit_cnt, 8);
        check("t6_rst_state", 32'(u_dut.state_q), 32'(IDLE));
        @(posedge cclk);
        #3;
        reset_n = 1'b1;
        repeat (2) @(posedge cclk);
        #1;
        send_beat(32'h7000_0001, 1, 1, 32'h0000_7701, 1, 1, 0);
        wait_drain();
        check("t6_post_pkt", pkt_cnt, 1);
        check("t6_post_credit", u_dut.credit_cnt, 7);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
